// File: rtl/mux_2to1_arbiter_pkg.sv
// Shared constants for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Owner recorded when an ownership state is entered.
    function automatic logic owner_of(input logic [1:0] st);
        return (st == ST_OWN_B) ? OWNER_B : OWNER_A;
    endfunction

endpackage

// File: rtl/mux_2to1_arbiter_if.sv
// Request/grant and data bundle between the two requesters and the arbiter.
interface mux_2to1_arbiter_if #(
    parameter int WIDTH = 1
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output req_a, req_b, a, b,
        input  gnt_a, gnt_b, sel, out, out_valid
    );

    modport slave (
        input  req_a, req_b, a, b,
        output gnt_a, gnt_b, sel, out, out_valid
    );
endinterface

// File: rtl/mux_2to1_arbiter_hold_counter.sv
// Tenure counter: counts owned cycles, saturates at MAX_HOLD-1 and flags it.
module hold_counter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TERM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == TERM);
endmodule

// File: rtl/mux_2to1_arbiter.sv
// Round-robin owner of the shared 2-to-1 mux: grants, select and registered data.
module mux_2to1_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_2to1_arbiter_if.slave   bus
);
    import mux_arb_pkg::*;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             gnt_a_q, gnt_b_q;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q;
    logic             hold_term_s;
    logic             state_chg_s;
    logic             own_s;

    assign own_s       = (state_q == ST_OWN_A) || (state_q == ST_OWN_B);
    assign state_chg_s = (state_d != state_q);

    hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_chg_s),
        .en_i   (own_s),
        .term_o (hold_term_s)
    );

    // Next owner: tie goes to whoever did not own last; handover skips IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    state_d = (last_q == OWNER_B) ? ST_OWN_A : ST_OWN_B;
                end else if (bus.req_a) begin
                    state_d = ST_OWN_A;
                end else if (bus.req_b) begin
                    state_d = ST_OWN_B;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_A: begin
                if (!bus.req_a) begin
                    state_d = bus.req_b ? ST_OWN_B : ST_IDLE;
                end else if (bus.req_b && hold_term_s) begin
                    state_d = ST_OWN_B;
                end else begin
                    state_d = ST_OWN_A;
                end
            end
            ST_OWN_B: begin
                if (!bus.req_b) begin
                    state_d = bus.req_a ? ST_OWN_A : ST_IDLE;
                end else if (bus.req_a && hold_term_s) begin
                    state_d = ST_OWN_A;
                end else begin
                    state_d = ST_OWN_B;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_owner, sel and data next values; all hold while IDLE.
    always_comb begin
        last_d = last_q;
        if (state_chg_s && (state_d != ST_IDLE)) begin
            last_d = owner_of(state_d);
        end else begin
            last_d = last_q;
        end
        case (state_d)
            ST_OWN_A: sel_d = SEL_A;
            ST_OWN_B: sel_d = SEL_B;
            default:  sel_d = sel_q;
        endcase
        case (state_q)
            ST_OWN_A: out_d = bus.a;
            ST_OWN_B: out_d = bus.b;
            default:  out_d = out_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= OWNER_B;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            sel_q       <= SEL_A;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_a_q     <= (state_d == ST_OWN_A);
            gnt_b_q     <= (state_d == ST_OWN_B);
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= own_s;
        end
    end

    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.sel       = sel_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule
